// File: rtl/lc3b_write_buffer_pkg.sv
// Shared types for the L1/L2 write-back buffer: line address, FSM states and
// the per-entry record held in the FIFO.
package lc3b_write_buffer_pkg;
   localparam int LC3B_LINE_W = 128;
   localparam int LC3B_ADDR_W = 16;

   typedef logic [LC3B_ADDR_W-5:0] lc3b_line_addr;

   typedef enum logic [1:0] {IDLE, RD_MISS, DRAIN} lc3b_wb_state;

   typedef struct packed {
      logic                   valid;
      lc3b_line_addr          laddr;
      logic [LC3B_LINE_W-1:0] data;
   } lc3b_wb_entry;
endpackage

// File: rtl/lc3b_wb_match.sv
// Combinational newest-match search over the FIFO, walked in age order from
// head so the last hit found is the youngest copy of the line.
module lc3b_wb_match
   import lc3b_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] i_valid,
   input  lc3b_line_addr    i_tag [DEPTH],
   input  logic [PW-1:0]    i_head,
   input  logic [PW:0]      i_count,
   input  lc3b_line_addr    i_laddr,
   input  logic             i_head_lock,
   output logic             o_hit,
   output logic [PW-1:0]    o_idx,
   output logic             o_locked
);
   logic [PW-1:0] w_pos;

   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      w_pos = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_pos = i_head + PW'(k);
         if (((PW+1)'(k) < i_count) && i_valid[w_pos] && (i_tag[w_pos] == i_laddr)) begin
            o_hit = 1'b1;
            o_idx = w_pos;
         end
      end
   end

   // Kept separate so the lock path never feeds back into the hit search.
   assign o_locked = o_hit && i_head_lock && (o_idx == i_head);
endmodule

// File: rtl/lc3b_write_buffer.sv
// Eviction buffer between L1 and L2: coalesces dirty lines, serves read hits,
// forwards read misses ahead of background drains.
module lc3b_write_buffer
   import lc3b_write_buffer_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int LINE_W       = 128,
   parameter int ADDR_W       = 16,
   parameter int DRAIN_THRESH = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              u_read,
   input  logic              u_write,
   input  logic [ADDR_W-1:0] u_addr,
   input  logic [LINE_W-1:0] u_wdata,
   output logic [LINE_W-1:0] u_rdata,
   output logic              u_resp,
   output logic              d_read,
   output logic              d_write,
   output logic [ADDR_W-1:0] d_addr,
   output logic [LINE_W-1:0] d_wdata,
   input  logic [LINE_W-1:0] d_rdata,
   input  logic              d_resp,
   input  logic              flush,
   output logic              empty,
   output logic              full
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C  = (PW+1)'(DEPTH);
   localparam logic [PW:0] THRESH_C = (PW+1)'(DRAIN_THRESH);

   lc3b_wb_entry  r_entry [DEPTH];
   logic [PW-1:0] r_head, r_tail;
   logic [PW:0]   r_count, w_count_next;
   lc3b_wb_state  r_state, w_state_next;

   logic              r_u_resp, r_d_read, r_d_write, r_empty, r_full;
   logic [LINE_W-1:0] r_u_rdata, r_d_wdata;
   logic [ADDR_W-1:0] r_d_addr;

   logic [DEPTH-1:0] w_valid;
   lc3b_line_addr    w_tag [DEPTH];
   lc3b_line_addr    w_laddr;
   logic [PW-1:0]    w_idx;
   logic w_hit, w_locked, w_head_lock, w_req_ok, w_rd_miss, w_rd_hit, w_drain_cond;
   logic w_start_miss, w_start_drain, w_pop, w_miss_done;
   logic w_coalesce, w_push, w_wr_done;
   logic w_unused_addr;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
      assign w_valid[gi] = r_entry[gi].valid;
      assign w_tag[gi]   = r_entry[gi].laddr;
   end

   assign w_laddr       = u_addr[ADDR_W-1:4];
   assign w_unused_addr = ^u_addr[3:0];

   lc3b_wb_match #(.DEPTH(DEPTH)) u_match (
      .i_valid    (w_valid),
      .i_tag      (w_tag),
      .i_head     (r_head),
      .i_count    (r_count),
      .i_laddr    (w_laddr),
      .i_head_lock(w_head_lock),
      .o_hit      (w_hit),
      .o_idx      (w_idx),
      .o_locked   (w_locked)
   );

   assign w_req_ok     = !r_u_resp;
   assign w_rd_miss    = w_req_ok && u_read && !w_hit;
   assign w_rd_hit     = w_req_ok && u_read && w_hit;
   assign w_drain_cond = (r_count >= THRESH_C) || (flush && !r_empty);
   // The head is frozen from the edge that snapshots it into d_wdata.
   assign w_head_lock  = (r_state == DRAIN) || w_start_drain;

   assign w_coalesce = w_req_ok && u_write && w_hit && !w_locked;
   assign w_push     = w_req_ok && u_write && !w_coalesce && (r_count != DEPTH_C);
   assign w_wr_done  = w_coalesce || w_push;

   always_comb begin
      w_state_next  = r_state;
      w_start_miss  = 1'b0;
      w_start_drain = 1'b0;
      w_pop         = 1'b0;
      w_miss_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rd_miss) begin
               w_state_next = RD_MISS;
               w_start_miss = 1'b1;
            end else if (w_drain_cond) begin
               w_state_next  = DRAIN;
               w_start_drain = 1'b1;
            end
         end
         RD_MISS: if (d_resp) begin
            w_state_next = IDLE;
            w_miss_done  = 1'b1;
         end
         DRAIN: if (d_resp) begin
            w_state_next = IDLE;
            w_pop        = 1'b1;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_entry[k].valid <= 1'b0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_push && (r_tail == PW'(k))) begin
               r_entry[k] <= '{valid: 1'b1, laddr: w_laddr, data: u_wdata};
            end else begin
               if (w_coalesce && (w_idx == PW'(k))) r_entry[k].data <= u_wdata;
               if (w_pop && (r_head == PW'(k)))     r_entry[k].valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_empty   <= 1'b1;
         r_full    <= 1'b0;
         r_u_resp  <= 1'b0;
         r_u_rdata <= '0;
         r_d_read  <= 1'b0;
         r_d_write <= 1'b0;
         r_d_addr  <= '0;
         r_d_wdata <= '0;
      end else begin
         r_u_resp <= w_wr_done || w_rd_hit || w_miss_done;
         if (w_rd_hit)         r_u_rdata <= r_entry[w_idx].data;
         else if (w_miss_done) r_u_rdata <= d_rdata;

         if (w_start_miss) begin
            r_d_read <= 1'b1;
            r_d_addr <= {w_laddr, 4'b0000};
         end else if (w_miss_done) begin
            r_d_read <= 1'b0;
         end

         if (w_start_drain) begin
            r_d_write <= 1'b1;
            r_d_addr  <= {r_entry[r_head].laddr, 4'b0000};
            r_d_wdata <= r_entry[r_head].data;
         end else if (w_pop) begin
            r_d_write <= 1'b0;
         end

         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         r_count <= w_count_next;
         r_empty <= (w_count_next == '0);
         r_full  <= (w_count_next == DEPTH_C);
      end
   end

   assign u_resp  = r_u_resp;
   assign u_rdata = r_u_rdata;
   assign d_read  = r_d_read;
   assign d_write = r_d_write;
   assign d_addr  = r_d_addr;
   assign d_wdata = r_d_wdata;
   assign empty   = r_empty;
   assign full    = r_full;
endmodule
